tdc_seq: RTL and testbench

Measurement sequencer for the multi-phase TDC. On a start command it runs a burst of N measurements by gating the TDC `mod` input (`arm`). Each measurement ends either on the TDC result strobe or on a timeout. Per burst it accumulates sum, min, max, success count and timeout count, then presents them on a valid/ready result port. It runs in the TDC output clock domain, the same clock as the TDC multiplier output.

---
 rtl/tdc_seq_if.sv | 24 ++
 rtl/tdc_seq.sv | 152 +++++++++++++++
 tb/tb_tdc_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_seq_if.sv
// Result port of the TDC measurement sequencer: valid/ready handshake plus burst statistics.
// The master (sequencer) drives the statistics; the slave (consumer) returns ready.
interface tdc_seq_if #(
  parameter int T_W = 20,
  parameter int N_W = 8
);
  logic               res_valid;
  logic               res_ready;
  logic [T_W+N_W-1:0] res_sum;
  logic [T_W-1:0]     res_min;
  logic [T_W-1:0]     res_max;
  logic [N_W-1:0]     res_cnt;
  logic [N_W-1:0]     res_to_cnt;

  modport master (
    output res_valid, res_sum, res_min, res_max, res_cnt, res_to_cnt,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_sum, res_min, res_max, res_cnt, res_to_cnt,
    output res_ready
  );
endinterface

// File: rtl/tdc_seq.sv
// Burst measurement sequencer for the multi-phase TDC: gates arm (TDC mod), times out
// each measurement and accumulates sum/min/max/success/timeout counts per burst.
module tdc_seq #(
  parameter int T_W     = 20,
  parameter int N_W     = 8,
  parameter int TO_W    = 16,
  parameter int GAP_CYC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N_W-1:0]  num_meas,
  input  logic [TO_W-1:0] timeout,
  output logic            arm,
  input  logic [T_W-1:0]  tdc_time,
  input  logic            tdc_dval,
  output logic            busy,
  output logic            cmd_err,
  tdc_seq_if.master       res
);
  localparam int G_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP, S_DONE} state_t;

  state_t state_reg, state_next;

  logic               start_q_reg;
  logic [N_W-1:0]     num_reg;
  logic [TO_W-1:0]    to_val_reg;
  logic [TO_W-1:0]    timer_reg;
  logic [G_W-1:0]     gap_reg;
  logic [T_W+N_W-1:0] sum_reg;
  logic [T_W-1:0]     min_reg;
  logic [T_W-1:0]     max_reg;
  logic [N_W-1:0]     cnt_reg;
  logic [N_W-1:0]     to_cnt_reg;

  logic arm_reg, busy_reg, cmd_err_reg, valid_reg;
  logic arm_next, busy_next, cmd_err_next, valid_next;

  logic           start_edge;
  logic           hit;
  logic           expire;
  logic           gap_end;
  logic [N_W:0]   done_cnt;

  // A start held across reset must be released and re-asserted to launch a burst.
  assign start_edge = start & ~start_q_reg;
  assign hit        = (state_reg == S_WAIT) && tdc_dval;
  assign expire     = (state_reg == S_WAIT) && !tdc_dval && (timer_reg == '0);
  assign gap_end    = (state_reg == S_GAP) && (gap_reg == '0);
  assign done_cnt   = {1'b0, cnt_reg} + {1'b0, to_cnt_reg};

  // State and registered control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      arm_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      cmd_err_reg <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      arm_reg     <= arm_next;
      busy_reg    <= busy_next;
      cmd_err_reg <= cmd_err_next;
      valid_reg   <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: if (start_edge && (num_meas != '0)) state_next = S_WAIT;
      S_WAIT: if (hit || expire) state_next = S_GAP;
      S_GAP: begin
        if (gap_end) state_next = (done_cnt < {1'b0, num_reg}) ? S_WAIT : S_DONE;
      end
      S_DONE: if (res.res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in registers aligned with it.
  always_comb begin
    arm_next     = (state_next == S_WAIT);
    busy_next    = (state_next != S_IDLE);
    valid_next   = (state_next == S_DONE);
    cmd_err_next = (state_reg == S_IDLE) && start_edge && (num_meas == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q_reg <= 1'b1;
      num_reg     <= '0;
      to_val_reg  <= '0;
      timer_reg   <= '0;
      gap_reg     <= '0;
      sum_reg     <= '0;
      min_reg     <= '1;
      max_reg     <= '0;
      cnt_reg     <= '0;
      to_cnt_reg  <= '0;
    end else begin
      start_q_reg <= start;
      unique case (state_reg)
        S_IDLE: begin
          if (state_next == S_WAIT) begin
            num_reg    <= num_meas;
            to_val_reg <= timeout;
            timer_reg  <= timeout;
            sum_reg    <= '0;
            min_reg    <= '1;
            max_reg    <= '0;
            cnt_reg    <= '0;
            to_cnt_reg <= '0;
          end
        end
        S_WAIT: begin
          if (hit) begin
            sum_reg <= sum_reg + {{N_W{1'b0}}, tdc_time};
            cnt_reg <= cnt_reg + 1'b1;
            if (tdc_time < min_reg) min_reg <= tdc_time;
            if (tdc_time > max_reg) max_reg <= tdc_time;
            gap_reg <= G_W'(GAP_CYC - 1);
          end else if (expire) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
            gap_reg    <= G_W'(GAP_CYC - 1);
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        S_GAP: begin
          // Timer reloads here so the next WAIT window starts from the full timeout.
          if (gap_reg != '0) gap_reg <= gap_reg - 1'b1;
          else               timer_reg <= to_val_reg;
        end
        default: ;
      endcase
    end
  end

  assign arm            = arm_reg;
  assign busy           = busy_reg;
  assign cmd_err        = cmd_err_reg;
  assign res.res_valid  = valid_reg;
  assign res.res_sum    = sum_reg;
  assign res.res_min    = min_reg;
  assign res.res_max    = max_reg;
  assign res.res_cnt    = cnt_reg;
  assign res.res_to_cnt = to_cnt_reg;
endmodule

// File: tb/tb_tdc_seq.sv
// Directed-vector bench for tdc_seq: stimulus and checks on the falling clock edge,
// expected values hand-computed from the burst scenarios below.
module tb_tdc_seq;
  localparam int T_W = 20;
  localparam int N_W = 8;
  localparam int TO_W = 16;

  logic            clk;
  logic            rst;
  logic            start;
  logic [N_W-1:0]  num_meas;
  logic [TO_W-1:0] timeout;
  logic            arm;
  logic [T_W-1:0]  tdc_time;
  logic            tdc_dval;
  logic            busy;
  logic            cmd_err;

  int n_vec;
  int n_err;

  tdc_seq_if #(.T_W(T_W), .N_W(N_W)) rif ();

  tdc_seq #(.T_W(T_W), .N_W(N_W), .TO_W(TO_W), .GAP_CYC(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_meas (num_meas),
    .timeout  (timeout),
    .arm      (arm),
    .tdc_time (tdc_time),
    .tdc_dval (tdc_dval),
    .busy     (busy),
    .cmd_err  (cmd_err),
    .res      (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input int n, input int to);
    start    = 1'b1;
    num_meas = N_W'(n);
    timeout  = TO_W'(to);
    tick();
    start = 1'b0;
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (arm && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (!arm && !rif.res_valid && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!rif.res_valid && n < 300) begin
      n++;
      tick();
    end
    chk("valid_wait", rif.res_valid, 1);
  endtask

  task automatic handshake();
    rif.res_ready = 1'b1;
    tick();
    rif.res_ready = 1'b0;
    chk("hs_valid_drop", rif.res_valid, 0);
    chk("hs_busy_drop", busy, 0);
  endtask

  initial begin
    int tv[3];
    int n;
    tv = '{500, 300, 700};
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    start = 1'b1;
    num_meas = 8'd3;
    timeout = 16'd10;
    tdc_time = '0;
    tdc_dval = 1'b0;
    rif.res_ready = 1'b0;

    // Reset with start held high
    repeat (3) tick();
    chk("rst_arm", arm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rif.res_valid, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_min", rif.res_min, 20'hFFFFF);
    chk("rst_max", rif.res_max, 0);
    chk("rst_sum", rif.res_sum, 0);
    chk("rst_cnt", rif.res_cnt, 0);
    chk("rst_to_cnt", rif.res_to_cnt, 0);
    rst = 1'b1;
    repeat (5) tick();
    chk("held_start_busy", busy, 0);
    chk("held_start_arm", arm, 0);
    start = 1'b0;
    tick();

    // Three successful measurements
    do_start(3, 100);
    chk("A_arm_rise", arm, 1);
    chk("A_busy_rise", busy, 1);
    for (int i = 0; i < 3; i++) begin
      repeat (10) tick();
      tdc_dval = 1'b1;
      tdc_time = T_W'(tv[i]);
      tick();
      tdc_dval = 1'b0;
      chk("A_arm_fall", arm, 0);
      count_low(n);
      chk("A_gap_len", n, 4);
    end
    chk("A_valid", rif.res_valid, 1);
    chk("A_sum", rif.res_sum, 1500);
    chk("A_min", rif.res_min, 300);
    chk("A_max", rif.res_max, 700);
    chk("A_cnt", rif.res_cnt, 3);
    chk("A_to_cnt", rif.res_to_cnt, 0);
    handshake();
    chk("A_hold_sum", rif.res_sum, 1500);

    // Two timeouts
    do_start(2, 5);
    for (int i = 0; i < 2; i++) begin
      count_high(n);
      chk("B_arm_len", n, 6);
      count_low(n);
      chk("B_gap_len", n, 4);
    end
    chk("B_valid", rif.res_valid, 1);
    chk("B_cnt", rif.res_cnt, 0);
    chk("B_to_cnt", rif.res_to_cnt, 2);
    chk("B_min", rif.res_min, 20'hFFFFF);
    chk("B_max", rif.res_max, 0);
    chk("B_sum", rif.res_sum, 0);
    handshake();

    // Result on the expiry cycle, then a late result during GAP
    do_start(1, 3);
    repeat (3) tick();
    tdc_dval = 1'b1;
    tdc_time = 20'd42;
    tick();
    chk("C_arm_fall", arm, 0);
    tdc_time = 20'd1;
    tick();
    tdc_dval = 1'b0;
    wait_valid();
    chk("C_cnt", rif.res_cnt, 1);
    chk("C_to_cnt", rif.res_to_cnt, 0);
    chk("C_sum", rif.res_sum, 42);
    chk("C_min", rif.res_min, 42);
    chk("C_max", rif.res_max, 42);
    handshake();

    // Zero-length burst rejected
    do_start(0, 10);
    chk("D_cmd_err", cmd_err, 1);
    chk("D_busy", busy, 0);
    tick();
    chk("D_cmd_err_drop", cmd_err, 0);

    // Start during a burst is ignored; long hold in DONE
    do_start(1, 50);
    tick();
    do_start(0, 3);
    chk("E_no_cmd_err", cmd_err, 0);
    chk("E_busy", busy, 1);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      chk("E_hold_valid", rif.res_valid, 1);
      chk("E_hold_busy", busy, 1);
      chk("E_hold_to_cnt", rif.res_to_cnt, 1);
      tick();
    end
    chk("E_cnt", rif.res_cnt, 0);
    handshake();
    chk("E_idle_to_cnt", rif.res_to_cnt, 1);

    // Asynchronous reset mid-WAIT
    do_start(1, 100);
    repeat (3) tick();
    chk("F_arm_pre", arm, 1);
    #2 rst = 1'b0;
    #1;
    chk("F_arm_async", arm, 0);
    chk("F_busy_async", busy, 0);
    chk("F_min_async", rif.res_min, 20'hFFFFF);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("F_idle_busy", busy, 0);
    chk("F_idle_arm", arm, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
